control_unit: RTL and testbench

Moore-style sequencer that drives the single-bus `DataPath` control inputs for the fetch and execute phases of the register-only instruction subset: ALU reg-reg, mul/div, neg/not, mfhi/mflo, nop, halt. It replaces testbench-driven control. It reads the opcode from the IR register output, steps through T0..T6, and stalls fetch on a memory-ready handshake. The block sits between the IR and every control pin of `DataPath`.

---
 rtl/control_unit.sv | 144 ++++++++++++++
 tb/tb_control_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Moore sequencer for the single-bus datapath: fetch (T0..T2) plus execute
// (T3..T6) for the register-only subset, with a T1 memory stall and a HALT trap.
module control_unit (
   input  logic        clock,
   input  logic        clear,
   input  logic        run,
   input  logic        mem_ready,
   input  logic [31:0] ir,
   output logic        PCout,
   output logic        MARin,
   output logic        IncPC,
   output logic        RZin,
   output logic        RZLOout,
   output logic        RZHIout,
   output logic        PCin,
   output logic        Read,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        gra,
   output logic        grb,
   output logic        grc,
   output logic        rin,
   output logic        rout,
   output logic        RYin,
   output logic        HIin,
   output logic        HIout,
   output logic        LOin,
   output logic        LOout,
   output logic [4:0]  ops,
   output logic [3:0]  state,
   output logic        illegal,
   output logic        retired,
   output logic        halted
);

   typedef enum logic [3:0] {
      IDLE = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
      T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, HALT = 4'd8
   } state_t;

   localparam logic [4:0] OP_DIV  = 5'b01111, OP_MUL  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001, OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_MFLO = 5'b11000, OP_MFHI = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010, OP_HALT = 5'b11011;

   state_t     cur, nxt, bnd;
   logic [4:0] opc;
   logic       is_alu2, is_muldiv, is_unary, is_mflo, is_mfhi, is_halt, is_bad;
   logic       last;
   logic       unused_ir;

   assign opc       = ir[31:27];
   assign unused_ir = ^ir[26:0];
   assign state     = cur;

   always_comb begin
      is_alu2   = (opc >= 5'b00011) && (opc <= 5'b01011);
      is_muldiv = (opc == OP_DIV) || (opc == OP_MUL);
      is_unary  = (opc == OP_NEG) || (opc == OP_NOT);
      is_mflo   = (opc == OP_MFLO);
      is_mfhi   = (opc == OP_MFHI);
      is_halt   = (opc == OP_HALT);
      is_bad    = !(is_alu2 || is_muldiv || is_unary || is_mflo || is_mfhi ||
                    is_halt || (opc == OP_NOP));
   end

   // Final execute state of the current instruction; anything unrecognised ends in T3.
   always_comb begin
      case (cur)
         T3:      last = !(is_alu2 || is_muldiv || is_unary);
         T4:      last = !(is_alu2 || is_muldiv);
         T5:      last = !is_muldiv;
         T6:      last = 1'b1;
         default: last = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) cur <= IDLE;
      else       cur <= nxt;
   end

   always_comb begin
      bnd = run ? T0 : IDLE;
      nxt = IDLE;
      case (cur)
         IDLE:    nxt = run ? T0 : IDLE;
         T0:      nxt = T1;
         T1:      nxt = mem_ready ? T2 : T1;
         T2:      nxt = T3;
         T3:      nxt = last ? (is_halt ? HALT : bnd) : T4;
         T4:      nxt = last ? bnd : T5;
         T5:      nxt = last ? bnd : T6;
         T6:      nxt = bnd;
         HALT:    nxt = HALT;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      {PCout, MARin, IncPC, RZin, RZLOout, RZHIout, PCin, Read, MDRin, MDRout, IRin} = '0;
      {gra, grb, grc, rin, rout, RYin, HIin, HIout, LOin, LOout} = '0;
      ops     = 5'd0;
      illegal = 1'b0;
      halted  = 1'b0;
      retired = last;
      case (cur)
         T0: {PCout, MARin, IncPC, RZin} = 4'b1111;
         T1: {RZLOout, PCin, Read, MDRin} = 4'b1111;
         T2: {MDRout, IRin} = 2'b11;
         T3: begin
            if (is_alu2)        {grb, rout, RYin} = 3'b111;
            else if (is_muldiv) {gra, rout, RYin} = 3'b111;
            else if (is_unary) begin
               {grb, rout, RZin} = 3'b111;
               ops = opc;
            end
            else if (is_mflo)   {gra, rin, LOout} = 3'b111;
            else if (is_mfhi)   {gra, rin, HIout} = 3'b111;
            else                illegal = is_bad;
         end
         T4: begin
            if (is_alu2) begin
               {grc, rout, RZin} = 3'b111;
               ops = opc;
            end
            else if (is_muldiv) begin
               {grb, rout, RZin} = 3'b111;
               ops = opc;
            end
            else if (is_unary)  {RZLOout, gra, rin} = 3'b111;
         end
         T5: begin
            if (is_alu2)        {RZLOout, gra, rin} = 3'b111;
            else if (is_muldiv) {RZLOout, LOin} = 2'b11;
         end
         T6: if (is_muldiv) {RZHIout, HIin} = 2'b11;
         HALT: halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: each scenario queues the expected
// (state, output vector) per cycle and compares after every rising edge.
module tb_control_unit;

   logic        clock = 1'b0;
   logic        clear, run, mem_ready;
   logic [31:0] ir;
   logic PCout, MARin, IncPC, RZin, RZLOout, RZHIout, PCin, Read, MDRin, MDRout, IRin;
   logic gra, grb, grc, rin, rout, RYin, HIin, HIout, LOin, LOout;
   logic [4:0]  ops;
   logic [3:0]  state;
   logic        illegal, retired, halted;
   logic [28:0] outv;

   control_unit dut (
      .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
      .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .RZin(RZin), .RZLOout(RZLOout),
      .RZHIout(RZHIout), .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout),
      .IRin(IRin), .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout),
      .RYin(RYin), .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
      .ops(ops), .state(state), .illegal(illegal), .retired(retired), .halted(halted)
   );

   always #5 clock = ~clock;

   assign outv = {ops, halted, retired, illegal, LOout, LOin, HIout, HIin, RYin, rout,
                  rin, grc, grb, gra, IRin, MDRout, MDRin, Read, PCin, RZHIout, RZLOout,
                  RZin, IncPC, MARin, PCout};

   localparam logic [3:0] S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3;
   localparam logic [3:0] S_T3 = 4'd4, S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_HALT = 4'd8;

   localparam logic [28:0] PCOUT = 29'h1 << 0,  MARIN = 29'h1 << 1,  INCPC = 29'h1 << 2;
   localparam logic [28:0] RZIN = 29'h1 << 3,   RZLOOUT = 29'h1 << 4, RZHIOUT = 29'h1 << 5;
   localparam logic [28:0] PCIN = 29'h1 << 6,   READ = 29'h1 << 7,   MDRIN = 29'h1 << 8;
   localparam logic [28:0] MDROUT = 29'h1 << 9, IRIN = 29'h1 << 10,  GRA = 29'h1 << 11;
   localparam logic [28:0] GRB = 29'h1 << 12,   GRC = 29'h1 << 13,   RIN = 29'h1 << 14;
   localparam logic [28:0] ROUT = 29'h1 << 15,  RYIN = 29'h1 << 16,  HIIN = 29'h1 << 17;
   localparam logic [28:0] HIOUT = 29'h1 << 18, LOIN = 29'h1 << 19,  LOOUT = 29'h1 << 20;
   localparam logic [28:0] ILL = 29'h1 << 21,   RET = 29'h1 << 22,   HLT = 29'h1 << 23;
   localparam logic [28:0] F0 = PCOUT | MARIN | INCPC | RZIN;
   localparam logic [28:0] F1 = RZLOOUT | PCIN | READ | MDRIN;
   localparam logic [28:0] F2 = MDROUT | IRIN;

   typedef struct {
      logic [3:0]  st;
      logic [28:0] v;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [28:0] opsv(input logic [4:0] o);
      return {o, 24'h0};
   endfunction

   function automatic void push(input logic [3:0] st, input logic [28:0] v);
      exp_t e;
      e.st = st;
      e.v  = v;
      sb.push_back(e);
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      int   n;
      run = 1'b1; mem_ready = 1'b1; ir = 32'h0;
      push(S_IDLE, '0); push(S_IDLE, '0); push(S_T0, F0);
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         clear = (i < 2);
         tick();
         e = sb.pop_front();
         checks++;
         if ({state, outv} !== {e.st, e.v}) begin
            errors++;
            $display("FAIL reset[%0d]: got state=%0d out=%h, want state=%0d out=%h",
                     i, state, outv, e.st, e.v);
         end
      end
   endtask

   task automatic test_alu_add();
      exp_t e;
      int   n;
      do_clear();
      ir = 32'h1800_0000; run = 1'b1; mem_ready = 1'b1;
      push(S_T0, F0); push(S_T1, F1); push(S_T2, F2);
      push(S_T3, GRB | ROUT | RYIN);
      push(S_T4, GRC | ROUT | RZIN | opsv(5'b00011));
      push(S_T5, RZLOOUT | GRA | RIN | RET);
      push(S_T0, F0);
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         tick();
         e = sb.pop_front();
         checks++;
         if ({state, outv} !== {e.st, e.v}) begin
            errors++;
            $display("FAIL add[%0d]: got state=%0d out=%h, want state=%0d out=%h",
                     i, state, outv, e.st, e.v);
         end
      end
   endtask

   task automatic test_mul();
      exp_t e;
      int   n;
      do_clear();
      ir = 32'h8000_0000; run = 1'b1; mem_ready = 1'b1;
      push(S_T0, F0); push(S_T1, F1); push(S_T2, F2);
      push(S_T3, GRA | ROUT | RYIN);
      push(S_T4, GRB | ROUT | RZIN | opsv(5'b10000));
      push(S_T5, RZLOOUT | LOIN);
      push(S_T6, RZHIOUT | HIIN | RET);
      push(S_IDLE, '0); push(S_IDLE, '0);
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         if (i == 6) run = 1'b0;
         tick();
         e = sb.pop_front();
         checks++;
         if ({state, outv} !== {e.st, e.v}) begin
            errors++;
            $display("FAIL mul[%0d]: got state=%0d out=%h, want state=%0d out=%h",
                     i, state, outv, e.st, e.v);
         end
      end
   endtask

   task automatic test_stall();
      exp_t e;
      int   n;
      do_clear();
      ir = 32'h1800_0000; run = 1'b1; mem_ready = 1'b1;
      push(S_T0, F0);
      push(S_T1, F1); push(S_T1, F1); push(S_T1, F1); push(S_T1, F1);
      push(S_T2, F2);
      push(S_T3, GRB | ROUT | RYIN);
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         mem_ready = !(i >= 2 && i <= 4);
         tick();
         e = sb.pop_front();
         checks++;
         if ({state, outv} !== {e.st, e.v}) begin
            errors++;
            $display("FAIL stall[%0d]: got state=%0d out=%h, want state=%0d out=%h",
                     i, state, outv, e.st, e.v);
         end
      end
      mem_ready = 1'b1;
   endtask

   task automatic test_mflo();
      exp_t e;
      int   n;
      do_clear();
      ir = 32'hC000_0000; run = 1'b1; mem_ready = 1'b1;
      push(S_T0, F0); push(S_T1, F1); push(S_T2, F2);
      push(S_T3, GRA | RIN | LOOUT | RET);
      push(S_T0, F0);
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         tick();
         e = sb.pop_front();
         checks++;
         if ({state, outv} !== {e.st, e.v}) begin
            errors++;
            $display("FAIL mflo[%0d]: got state=%0d out=%h, want state=%0d out=%h",
                     i, state, outv, e.st, e.v);
         end
      end
   endtask

   task automatic test_halt();
      exp_t e;
      int   n;
      do_clear();
      ir = 32'hD800_0000; run = 1'b1; mem_ready = 1'b1;
      push(S_T0, F0); push(S_T1, F1); push(S_T2, F2); push(S_T3, RET);
      for (int k = 0; k < 10; k++) push(S_HALT, HLT);
      push(S_IDLE, '0);
      push(S_T0, F0);
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         clear = (i == 14);
         tick();
         e = sb.pop_front();
         checks++;
         if ({state, outv} !== {e.st, e.v}) begin
            errors++;
            $display("FAIL halt[%0d]: got state=%0d out=%h, want state=%0d out=%h",
                     i, state, outv, e.st, e.v);
         end
      end
   endtask

   task automatic test_illegal();
      exp_t e;
      int   n;
      do_clear();
      ir = 32'hA000_0000; run = 1'b1; mem_ready = 1'b1;
      push(S_T0, F0); push(S_T1, F1); push(S_T2, F2);
      push(S_T3, ILL | RET);
      push(S_T0, F0);
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         tick();
         e = sb.pop_front();
         checks++;
         if ({state, outv} !== {e.st, e.v}) begin
            errors++;
            $display("FAIL illegal[%0d]: got state=%0d out=%h, want state=%0d out=%h",
                     i, state, outv, e.st, e.v);
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   n;
      do_clear();
      ir = 32'h2000_0000; run = 1'b1; mem_ready = 1'b1;
      push(S_T0, F0); push(S_T1, F1); push(S_T2, F2);
      push(S_T3, GRB | ROUT | RYIN);
      push(S_T4, GRC | ROUT | RZIN | opsv(5'b00100));
      push(S_IDLE, '0); push(S_IDLE, '0);
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         clear = (i == 5);
         if (i == 6) run = 1'b0;
         tick();
         e = sb.pop_front();
         checks++;
         if ({state, outv} !== {e.st, e.v}) begin
            errors++;
            $display("FAIL reset_mid[%0d]: got state=%0d out=%h, want state=%0d out=%h",
                     i, state, outv, e.st, e.v);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   n;
      do_clear();
      ir = 32'h8800_0000; run = 1'b1; mem_ready = 1'b1;
      push(S_T0, F0); push(S_T1, F1); push(S_T2, F2);
      push(S_T3, GRB | ROUT | RZIN | opsv(5'b10001));
      push(S_T4, RZLOOUT | GRA | RIN | RET);
      push(S_T0, F0); push(S_T1, F1); push(S_T2, F2);
      push(S_T3, RET);
      push(S_IDLE, '0);
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         if (i == 6) ir = 32'hD000_0000;
         if (i == 9) run = 1'b0;
         tick();
         e = sb.pop_front();
         checks++;
         if ({state, outv} !== {e.st, e.v}) begin
            errors++;
            $display("FAIL back_to_back[%0d]: got state=%0d out=%h, want state=%0d out=%h",
                     i, state, outv, e.st, e.v);
         end
      end
   endtask

   initial begin
      clear = 1'b1; run = 1'b0; mem_ready = 1'b1; ir = 32'h0;
      test_reset();
      test_alu_add();
      test_mul();
      test_stall();
      test_mflo();
      test_halt();
      test_illegal();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
